// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache port, D-cache port and shared memory bus around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_mem_read;
  logic              i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_mem_read, i_mem_write, i_mem_addr, i_mem_wdata,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache (port 0)
// and D-cache (port 1); one transaction at a time through IDLE -> BUSY -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] line_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              i_ready_q;
  logic              d_ready_q;

  logic              req_i;
  logic              req_d;
  logic              grant_d;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that did not win last time is chosen; write beats read.
  always_comb begin
    req_i     = bus.i_mem_read | bus.i_mem_write;
    req_d     = bus.d_mem_read | bus.d_mem_write;
    grant_d   = req_d & (~req_i | ~last_grant);
    sel_write = grant_d ? bus.d_mem_write : bus.i_mem_write;
    sel_addr  = grant_d ? bus.d_mem_addr  : bus.i_mem_addr;
    sel_wdata = grant_d ? bus.d_mem_wdata : bus.i_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      owner       <= 1'b0;
      op_write    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          if (req_i | req_d) begin
            owner       <= grant_d;
            last_grant  <= grant_d;
            op_write    <= sel_write;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_read_q  <= ~sel_write;
            mem_write_q <= sel_write;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Writes also capture mem_rdata so the port sees whatever memory returned.
          if (bus.mem_ready) begin
            line_q      <= bus.mem_rdata;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_ready_q   <= ~owner;
            d_ready_q   <= owner;
            state       <= RESP;
          end
        end
        RESP: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_ready_q   <= 1'b0;
          d_ready_q   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = (state == BUSY) ? addr_q  : '0;
  assign bus.mem_wdata   = (state == BUSY) ? wdata_q : '0;
  assign bus.i_mem_rdata = line_q;
  assign bus.d_mem_rdata = line_q;
  assign bus.i_mem_ready = i_ready_q;
  assign bus.d_mem_ready = d_ready_q;

  logic unused_op;
  assign unused_op = op_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push expected memory transactions,
// a monitor pops them as the shared bus and port readies respond.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef struct {
    bit                port;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                delay;
  } txn_t;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  txn_t exp_q[$];
  txn_t cur;
  bit   have_cur;
  bit   prev_strobe;
  int   strobe_cnt;
  int   ready_cnt;
  int   busy_cnt;
  int   mem_delay;
  bit   inject_ready;
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    if (a == 28'h0000010) return {16{8'hA5}};
    w = 32'h5EED0000 ^ {4'h0, a};
    return {4{w}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit rd, input bit wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    txn_t t;
    t.port  = port;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = mem_data(addr);
    t.delay = mem_delay;
    exp_q.push_back(t);
    if (port) begin
      bus.d_mem_read  = rd;
      bus.d_mem_write = wr;
      bus.d_mem_addr  = addr;
      bus.d_mem_wdata = wdata;
    end else begin
      bus.i_mem_read  = rd;
      bus.i_mem_write = wr;
      bus.i_mem_addr  = addr;
      bus.i_mem_wdata = wdata;
    end
  endtask

  // A port drops its request as soon as it sees its own ready pulse.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.i_mem_ready) begin
        bus.i_mem_read  = 1'b0;
        bus.i_mem_write = 1'b0;
      end
      if (bus.d_mem_ready) begin
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
      end
    end
  endtask

  task automatic runUntilDone(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || have_cur || bus.i_mem_read || bus.i_mem_write ||
            bus.d_mem_read || bus.d_mem_write) && n < budget) begin
      stepCycles(1);
      n++;
    end
    if (n >= budget) checkOutput("timeout", 128'(1), 128'(0));
  endtask

  // Memory model: answers a strobe after mem_delay cycles, or on demand via inject_ready.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    busy_cnt      = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
      end else if (inject_ready) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {8{16'hDEAD}};
      end else if (bus.mem_read || bus.mem_write) begin
        busy_cnt++;
        if (busy_cnt >= mem_delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_data(bus.mem_addr);
          busy_cnt      = 0;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Monitor: each new strobe pops the next expected transaction, each ready retires it.
  initial begin
    have_cur    = 1'b0;
    prev_strobe = 1'b0;
    strobe_cnt  = 0;
    ready_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur    = 1'b0;
        prev_strobe = 1'b0;
        strobe_cnt  = 0;
      end else begin
        checkOutput("strobe_excl", 128'(bus.mem_read & bus.mem_write), 128'(0));
        checkOutput("ready_excl", 128'(bus.i_mem_ready & bus.d_mem_ready), 128'(0));
        if (bus.mem_read || bus.mem_write) begin
          if (!prev_strobe) begin
            if (exp_q.size() == 0) begin
              checkOutput("unexp_strobe", 128'(1), 128'(0));
              have_cur = 1'b0;
            end else begin
              cur        = exp_q.pop_front();
              have_cur   = 1'b1;
              strobe_cnt = 0;
              checkOutput("op_write", 128'(bus.mem_write), 128'(cur.wr));
              checkOutput("op_read", 128'(bus.mem_read), 128'(!cur.wr));
              checkOutput("mem_wdata", 128'(bus.mem_wdata), 128'(cur.wdata));
            end
          end
          if (have_cur) checkOutput("addr_hold", 128'(bus.mem_addr), 128'(cur.addr));
          strobe_cnt++;
        end
        if (bus.i_mem_ready || bus.d_mem_ready) begin
          ready_cnt++;
          if (!have_cur) begin
            checkOutput("unexp_ready", 128'(1), 128'(0));
          end else begin
            checkOutput("ready_port", 128'(bus.d_mem_ready), 128'(cur.port));
            checkOutput("port_rdata", cur.port ? bus.d_mem_rdata : bus.i_mem_rdata, cur.rdata);
            checkOutput("strobe_cycles", 128'(strobe_cnt), 128'(cur.delay));
            have_cur = 1'b0;
          end
          checkOutput("rdata_shared", bus.i_mem_rdata, bus.d_mem_rdata);
        end
        prev_strobe = bus.mem_read | bus.mem_write;
      end
    end
  end

  initial begin
    int saved_ready;
    bit p;
    bit w;
    logic [ADDR_W-1:0] a;
    total           = 0;
    bad             = 0;
    mem_delay       = 3;
    inject_ready    = 1'b0;
    bus.i_mem_read  = 1'b0;
    bus.i_mem_write = 1'b0;
    bus.i_mem_addr  = '0;
    bus.i_mem_wdata = '0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_read", 128'(bus.mem_read), 128'(0));
    checkOutput("rst_mem_write", 128'(bus.mem_write), 128'(0));
    checkOutput("rst_i_ready", 128'(bus.i_mem_ready), 128'(0));
    checkOutput("rst_d_ready", 128'(bus.d_mem_ready), 128'(0));
    checkOutput("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    checkOutput("rst_mem_wdata", bus.mem_wdata, 128'(0));
    checkOutput("rst_i_rdata", bus.i_mem_rdata, 128'(0));
    checkOutput("rst_d_rdata", bus.d_mem_rdata, 128'(0));
    stepCycles(2);

    $display("[TB] single read on port 0");
    applyStimulus(1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0);
    rst_n = 1'b1;
    stepCycles(1);
    checkOutput("first_grant_read", 128'(bus.mem_read), 128'(1));
    checkOutput("first_grant_addr", 128'(bus.mem_addr), 128'(28'h0000010));
    checkOutput("first_no_d_ready", 128'(bus.d_mem_ready), 128'(0));
    runUntilDone(50);

    $display("[TB] tie after reset, port 1 first");
    mem_delay = 2;
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h0000200, 128'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 28'h0000100, 128'h0);
    runUntilDone(60);

    $display("[TB] write-back then allocate on port 1");
    applyStimulus(1'b1, 1'b0, 1'b1, 28'h0ABCDEF, 128'h1234);
    stepCycles(1);
    checkOutput("wb_mem_write", 128'(bus.mem_write), 128'(1));
    checkOutput("wb_mem_read", 128'(bus.mem_read), 128'(0));
    checkOutput("wb_mem_wdata", bus.mem_wdata, 128'h1234);
    runUntilDone(50);
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h0ABCDEF, 128'h0);
    runUntilDone(50);

    $display("[TB] tie after port 1 owned last, port 0 first");
    applyStimulus(1'b0, 1'b1, 1'b0, 28'h0000300, 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h0000400, 128'h0);
    runUntilDone(60);

    $display("[TB] port 1 request held off while port 0 busy");
    mem_delay = 5;
    applyStimulus(1'b0, 1'b1, 1'b0, 28'h0000500, 128'h0);
    stepCycles(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 28'h0000600, 128'h0);
    stepCycles(2);
    checkOutput("hold_addr", 128'(bus.mem_addr), 128'(28'h0000500));
    runUntilDone(80);

    $display("[TB] read and write together on port 0");
    mem_delay = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 28'h0000700, 128'hBEEF);
    stepCycles(1);
    checkOutput("rw_mem_write", 128'(bus.mem_write), 128'(1));
    checkOutput("rw_mem_read", 128'(bus.mem_read), 128'(0));
    runUntilDone(50);

    $display("[TB] random single transactions");
    for (int i = 0; i < 6; i++) begin
      p         = 1'($urandom_range(0, 1));
      w         = 1'($urandom_range(0, 1));
      a         = 28'($urandom());
      mem_delay = $urandom_range(1, 4);
      applyStimulus(p, !w, w, a, {4{$urandom()}});
      runUntilDone(50);
    end

    $display("[TB] reset during busy");
    mem_delay = 50;
    applyStimulus(1'b0, 1'b1, 1'b0, 28'h0000800, 128'h0);
    stepCycles(2);
    checkOutput("busy_before_rst", 128'(bus.mem_read), 128'(1));
    saved_ready = ready_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_read", 128'(bus.mem_read), 128'(0));
    checkOutput("rst_async_addr", 128'(bus.mem_addr), 128'(0));
    bus.i_mem_read = 1'b0;
    inject_ready   = 1'b1;
    stepCycles(1);
    inject_ready = 1'b0;
    rst_n        = 1'b1;
    inject_ready = 1'b1;
    stepCycles(1);
    inject_ready = 1'b0;
    stepCycles(4);
    checkOutput("rst_no_ready", 128'(ready_cnt), 128'(saved_ready));
    checkOutput("rst_idle_strobe", 128'(bus.mem_read | bus.mem_write), 128'(0));
    checkOutput("rst_line_clear", bus.i_mem_rdata, 128'(0));
    checkOutput("rst_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block address width (word address bits [29:2]).
REQ-002 Parameter DATA_W, default 128, cache-line width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 i_mem_read, i_mem_write  input  1 each  I-cache port (port 0) line read / write request, level, held until i_mem_ready.
REQ-006 i_mem_addr  input  ADDR_W  port 0 line address; i_mem_wdata  input  DATA_W  port 0 write line.
REQ-007 i_mem_rdata  output  DATA_W  port 0 read line; i_mem_ready  output  1  port 0 completion pulse.
REQ-008 d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: D-cache port (port 1), same widths and meanings as port 0.
REQ-009 mem_read, mem_write  output  1  shared memory command strobes, level.
REQ-010 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  shared memory address / write line.
REQ-011 mem_rdata  input  DATA_W; mem_ready  input  1  memory read data / completion.

Function
REQ-012 FSM states IDLE, BUSY, RESP; exactly one state active.
REQ-013 IDLE: port requesting if read|write; no request -> stay IDLE, all outputs low.
REQ-014 IDLE, one port requesting -> grant it; both requesting -> grant port != last_grant (round-robin); last_grant resets to 0, so the first tie goes to port 1.
REQ-015 On grant: latch owner, addr, wdata, op into registers, update last_grant, go BUSY next cycle.
REQ-016 op = write if requester's write=1 (write wins if read and write both high), else read.
REQ-017 BUSY: mem_read=(op==read), mem_write=(op==write), mem_addr/mem_wdata from latched registers only; requester inputs ignored while not IDLE.
REQ-018 BUSY, mem_ready=1: capture mem_rdata into line buffer (writes too), go RESP; mem_read/mem_write low from next cycle.
REQ-019 BUSY, mem_ready=0: stay BUSY indefinitely; no timeout.
REQ-020 RESP: owner's *_mem_ready=1 for exactly one cycle, owner's *_mem_rdata = line buffer; go IDLE next cycle.
REQ-021 Non-owner *_mem_ready always 0; both *_mem_rdata driven from line buffer at all times.
REQ-022 mem_ready in IDLE or RESP ignored; no state change.
REQ-023 Latency: request first sampled in IDLE at edge N -> memory strobe high cycle N+1; mem_ready at cycle M -> port ready at M+1; next grant earliest M+2, strobe M+3.
REQ-024 Never mem_read and mem_write simultaneously high; never both port readies high.
REQ-025 All outputs registered or decoded from registered state only; no combinational path from any input to any output.
REQ-026 A port dropping its request while not owner is not an error; arbitration uses IDLE-cycle sampling only.

Reset
REQ-027 rst_n=0 immediately (no clock) forces state=IDLE, last_grant=0, owner=0, op=read, latched addr/wdata/line buffer=0.
REQ-028 During and after reset: mem_read=mem_write=0, i_mem_ready=d_mem_ready=0, all data/address outputs 0.
REQ-029 Reset asserted mid-BUSY aborts transaction; no ready pulse issued to either port afterward.
REQ-030 First grant possible on first rising edge after rst_n deasserts.

Verification
REQ-031 Single read: i_mem_read=1, i_mem_addr=28'h0000010, memory ready 3 cycles later with rdata=128'hA5..A5 -> mem_read=1 with mem_addr=28'h0000010 for 3 cycles, then i_mem_ready pulse 1 cycle with i_mem_rdata=128'hA5..A5, d_mem_ready stays 0.
REQ-032 Tie after reset: both ports read same cycle -> port 1 served first, port 0 next; repeat tie -> port 0 served first (alternation).
REQ-033 Write-back then allocate: d_mem_write=1, addr=28'h0ABCDEF, wdata=128'h1234 -> mem_write=1, mem_wdata=128'h1234; after d_mem_ready, d_mem_read=1 -> new BUSY with mem_read=1, mem_write never overlapping.
REQ-034 Hold while busy: port 0 owns BUSY, port 1 raises request with changed addr -> mem_addr unchanged until port 0's RESP; port 1 granted next IDLE.
REQ-035 Reset mid-op: rst_n=0 in BUSY, mem_ready=1 next cycle -> mem_read drops asynchronously, no port ready pulse, state IDLE.
REQ-036 Illegal read+write on port 0 simultaneously -> mem_write=1 only, mem_read=0.
